// File: rtl/direct_mapped_cache_if.sv
// CPU-side and backing-RAM-side signal bundle for direct_mapped_cache.
// master: the environment (CPU requester plus RAM responder).
// slave:  the cache itself.
interface direct_mapped_cache_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ready;
  logic                  cpu_hit;
  logic                  flush;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate cache.
// Lookup is combinational in IDLE; every output is a register.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module direct_mapped_cache #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int LINES      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  direct_mapped_cache_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  wr_hit_q, wr_hit_d;
  logic                  cpu_ready_q, cpu_ready_d;
  logic                  cpu_hit_q, cpu_hit_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // Line storage; contents are don't-care until the matching valid bit is set.
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  lookup_hit;

  logic                  line_we;
  logic                  tag_we;
  logic [IDX_W-1:0]      line_idx;
  logic [DATA_WIDTH-1:0] line_wdata;

  assign req_idx    = bus.cpu_addr[IDX_W-1:0];
  assign req_tag    = bus.cpu_addr[ADDR_WIDTH-1:IDX_W];
  // The outstanding RAM address doubles as the fill target; it is held stable.
  assign fill_idx   = mem_addr_q[IDX_W-1:0];
  assign fill_tag   = mem_addr_q[ADDR_WIDTH-1:IDX_W];
  assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_hit   = cpu_hit_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Next-state, output and line-write decode for the request FSM.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    // A flush seen while busy is remembered and applied once back in IDLE.
    flush_pend_d = flush_pend_q | (bus.flush && (state_q != IDLE));
    wr_hit_d     = wr_hit_q;
    cpu_ready_d  = 1'b0;
    cpu_hit_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    line_idx     = req_idx;
    line_wdata   = bus.cpu_wdata;

    case (state_q)
      IDLE: begin
        if (bus.flush || flush_pend_q) begin
          // Flush takes the whole cycle; any pending request waits one cycle.
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end else if (bus.cpu_req) begin
          if (bus.cpu_we) begin
            state_d     = WRITE;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
            wr_hit_d    = lookup_hit;
            // Write hit refreshes the line now; a write miss allocates nothing.
            line_we     = lookup_hit;
          end else if (lookup_hit) begin
            state_d     = RESP;
            cpu_ready_d = 1'b1;
            cpu_hit_d   = 1'b1;
            cpu_rdata_d = data_mem[req_idx];
          end else begin
            state_d    = FILL;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = bus.cpu_addr;
          end
        end
      end
      FILL: begin
        if (bus.mem_ack) begin
          line_we           = 1'b1;
          tag_we            = 1'b1;
          line_idx          = fill_idx;
          line_wdata        = bus.mem_rdata;
          valid_d[fill_idx] = 1'b1;
          cpu_rdata_d       = bus.mem_rdata;
          cpu_ready_d       = 1'b1;
          cpu_hit_d         = 1'b0;
          mem_req_d         = 1'b0;
          mem_we_d          = 1'b0;
          state_d           = RESP;
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          cpu_ready_d = 1'b1;
          cpu_hit_d   = wr_hit_q;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any RAM transaction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      wr_hit_q     <= 1'b0;
      cpu_ready_q  <= 1'b0;
      cpu_hit_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      wr_hit_q     <= wr_hit_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_hit_q    <= cpu_hit_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Line data / tag arrays; no reset, validity is tracked separately.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_mem[line_idx] <= line_wdata;
    end
    if (tag_we) begin
      tag_mem[line_idx] <= fill_tag;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  // Saturating hit/miss tallies, one step per completion pulse; flush leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (cpu_ready_q) begin
      if (cpu_hit_q) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
